// File: rtl/ibus_prefetch_buffer_pkg.sv
// Shared bus constants, FSM state encoding and FIFO entry layout for the
// instruction-bus prefetch buffer.
package ibus_prefetch_buffer_pkg;

    localparam int XLEN          = 32;
    localparam int BUS_WIDTH     = 32;
    localparam int BUS_ACC_CNT   = 3;
    localparam int ACC_W         = $clog2(BUS_ACC_CNT);
    localparam int ACC_WORD      = 2;
    localparam int IBUS_PF_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } pf_state_t;

    typedef struct packed {
        logic [BUS_WIDTH-1:0] data;
        logic                 fault;
    } pf_entry_t;

    // Only aligned word reads are serviceable instruction fetches.
    function automatic logic illegal_fetch(input logic             w_rb,
                                           input logic [ACC_W-1:0] acc,
                                           input logic [1:0]       addr_lo);
        return w_rb || (acc != ACC_W'(ACC_WORD)) || (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/ibus_prefetch_buffer_fifo.sv
// Circular buffer of prefetched {data, fault} entries; flush empties it in one
// cycle and takes priority over a same-cycle push or pop.
module pf_fifo
    import ibus_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = IBUS_PF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  pf_entry_t        wr_entry,
    output pf_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    pf_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wr_entry;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ibus_prefetch_buffer.sv
// Sequential instruction prefetcher between the core fetch port and the SRAM
// instruction bus; non-sequential fetches flush and restart the stream.
module ibus_prefetch_buffer
    import ibus_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH     = IBUS_PF_DEPTH,
    parameter bit PF_ENABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      c_addr,
    input  logic                 c_w_rb,
    input  logic [ACC_W-1:0]     c_acc,
    input  logic [BUS_WIDTH-1:0] c_wdata,
    input  logic                 c_req,
    output logic [BUS_WIDTH-1:0] c_rdata,
    output logic                 c_resp,
    output logic                 c_fault,
    output logic [XLEN-1:0]      m_addr,
    output logic                 m_w_rb,
    output logic [ACC_W-1:0]     m_acc,
    output logic [BUS_WIDTH-1:0] m_wdata,
    output logic                 m_req,
    input  logic [BUS_WIDTH-1:0] m_rdata,
    input  logic                 m_resp,
    input  logic                 m_fault
);

    localparam int              CNT_W      = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

    pf_state_t        state, state_n;
    logic [XLEN-1:0]  fetch_addr, fetch_addr_n;
    logic [XLEN-1:0]  head_addr, head_addr_n;
    logic [XLEN-1:0]  m_addr_n;
    logic             pf_stop, pf_stop_n;
    logic [XLEN-1:0]  fetch_inc;
    logic             fetch_carry;
    logic             accept, illegal, hit, pending, miss;
    logic             push, pop, stop_now;
    pf_entry_t        head, wr_entry;
    logic             full, empty;
    logic [CNT_W-1:0] count, count_after;
    logic             unused_wdata;

    assign unused_wdata = ^c_wdata;

    // The core holds c_req through the c_resp cycle, so ignore it there.
    assign accept  = c_req && !c_resp;
    assign illegal = illegal_fetch(c_w_rb, c_acc, c_addr[1:0]);
    assign hit     = accept && !illegal && !empty && (c_addr == head_addr);
    // Empty buffer with the wanted word already in flight (or queued behind a drain).
    assign pending = (state != ST_IDLE) && empty && (c_addr == fetch_addr);
    assign miss    = accept && !illegal && !hit && !pending;

    assign push     = (state == ST_FETCH) && m_resp && !miss;
    assign pop      = hit;
    assign {fetch_carry, fetch_inc} = {1'b0, fetch_addr} + {1'b0, WORD_BYTES};
    assign stop_now = m_fault || fetch_carry;
    assign wr_entry = '{data: m_rdata, fault: m_fault};

    always_comb begin
        count_after = count;
        if (push && !pop)      count_after = count + CNT_W'(1);
        else if (pop && !push) count_after = count - CNT_W'(1);
    end

    pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .flush    (miss),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    always_comb begin
        state_n      = state;
        fetch_addr_n = fetch_addr;
        head_addr_n  = hit ? (head_addr + WORD_BYTES) : head_addr;
        m_addr_n     = m_addr;
        pf_stop_n    = pf_stop;
        if (miss) begin
            head_addr_n  = c_addr;
            fetch_addr_n = c_addr;
            pf_stop_n    = 1'b0;
        end
        unique case (state)
            ST_IDLE: begin
                if (miss) begin
                    state_n  = ST_FETCH;
                    m_addr_n = c_addr;
                end else if (PF_ENABLE && !pf_stop && !full) begin
                    state_n  = ST_FETCH;
                    m_addr_n = fetch_addr;
                end
            end
            ST_FETCH: begin
                if (miss) begin
                    // A response landing in the flush cycle closes the transaction already.
                    if (m_resp) m_addr_n = c_addr;
                    else        state_n  = ST_DRAIN;
                end else if (m_resp) begin
                    fetch_addr_n = fetch_inc;
                    pf_stop_n    = pf_stop || stop_now;
                    if (PF_ENABLE && !stop_now && (count_after != CNT_W'(DEPTH)))
                        m_addr_n = fetch_inc;
                    else
                        state_n  = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (m_resp) begin
                    state_n  = ST_FETCH;
                    m_addr_n = miss ? c_addr : fetch_addr;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Prefetch starts held off so nothing is fetched until the first miss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            fetch_addr <= '0;
            head_addr  <= '0;
            m_addr     <= '0;
            pf_stop    <= 1'b1;
            c_resp     <= 1'b0;
            c_fault    <= 1'b0;
            c_rdata    <= '0;
        end else begin
            state      <= state_n;
            fetch_addr <= fetch_addr_n;
            head_addr  <= head_addr_n;
            m_addr     <= m_addr_n;
            pf_stop    <= pf_stop_n;
            c_resp     <= accept && (illegal || hit);
            c_fault    <= accept && (illegal || (hit && head.fault));
            if (accept && illegal) c_rdata <= '0;
            else if (hit)          c_rdata <= head.data;
        end
    end

    assign m_req   = (state != ST_IDLE);
    assign m_w_rb  = 1'b0;
    assign m_acc   = ACC_W'(ACC_WORD);
    assign m_wdata = '0;

endmodule

// File: tb/tb_ibus_prefetch_buffer.sv
// Directed bench: core-side scoreboard of expected fetch results plus a
// fixed-latency SRAM responder that logs every downstream request.
module tb_ibus_prefetch_buffer;
    import ibus_prefetch_buffer_pkg::*;

    localparam int LAT = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [XLEN-1:0]      c_addr;
    logic                 c_w_rb;
    logic [ACC_W-1:0]     c_acc;
    logic [BUS_WIDTH-1:0] c_wdata;
    logic                 c_req;
    logic [BUS_WIDTH-1:0] c_rdata;
    logic                 c_resp;
    logic                 c_fault;
    logic [XLEN-1:0]      m_addr;
    logic                 m_w_rb;
    logic [ACC_W-1:0]     m_acc;
    logic [BUS_WIDTH-1:0] m_wdata;
    logic                 m_req;
    logic [BUS_WIDTH-1:0] m_rdata;
    logic                 m_resp;
    logic                 m_fault;

    always #5 clk = ~clk;

    ibus_prefetch_buffer #(.DEPTH(2), .PF_ENABLE(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .c_addr  (c_addr),
        .c_w_rb  (c_w_rb),
        .c_acc   (c_acc),
        .c_wdata (c_wdata),
        .c_req   (c_req),
        .c_rdata (c_rdata),
        .c_resp  (c_resp),
        .c_fault (c_fault),
        .m_addr  (m_addr),
        .m_w_rb  (m_w_rb),
        .m_acc   (m_acc),
        .m_wdata (m_wdata),
        .m_req   (m_req),
        .m_rdata (m_rdata),
        .m_resp  (m_resp),
        .m_fault (m_fault)
    );

    typedef struct {
        logic [31:0] data;
        logic        fault;
        bit          chk_data;
    } exp_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        sb[$];
    logic [31:0] issued[$];
    int          resp_cyc [logic [31:0]];
    logic [31:0] fault_addr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SRAM model: answers each request LAT cycles after it is first seen.
    initial begin
        int cnt;
        cnt = 0;
        m_resp = 1'b0;
        m_fault = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                m_resp = 1'b0; m_fault = 1'b0; cnt = 0;
            end else if (m_resp) begin
                m_resp = 1'b0; m_fault = 1'b0; cnt = 0;
            end else if (m_req) begin
                if (cnt == 0) begin
                    issued.push_back(m_addr);
                    check("m_addr_aligned", m_addr[1:0], 2'b00);
                end
                cnt++;
                if (cnt == LAT) begin
                    m_resp  = 1'b1;
                    m_rdata = sram_word(m_addr);
                    m_fault = (m_addr == fault_addr);
                    resp_cyc[m_addr] = cyc;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [1:0] acc, input logic w_rb,
                         input string tag, output int lat, output int at_cyc);
        exp_t e, got;
        bit   legal;
        legal      = !w_rb && (acc == 2'd2) && (addr[1:0] == 2'b00);
        e.data     = legal ? sram_word(addr) : 32'h0;
        e.fault    = legal ? (addr == fault_addr) : 1'b1;
        e.chk_data = legal;
        sb.push_back(e);
        c_addr = addr; c_acc = acc; c_w_rb = w_rb; c_req = 1'b1;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!c_resp && lat < 200);
        at_cyc = cyc;
        c_req = 1'b0; c_w_rb = 1'b0; c_acc = 2'd2;
        check({tag, "_resp"}, c_resp, 1'b1);
        if (c_resp) begin
            got = sb.pop_front();
            check({tag, "_fault"}, c_fault, got.fault);
            if (got.chk_data) check({tag, "_data"}, c_rdata, got.data);
        end
        @(posedge clk); #1;
        check({tag, "_pulse"}, c_resp, 1'b0);
    endtask

    task automatic wait_maddr(input logic [31:0] addr, input string tag);
        int k;
        k = 0;
        while (!(m_req === 1'b1 && m_addr === addr) && k < 60) begin
            @(posedge clk); #1; k++;
        end
        check({tag, "_seen"}, (m_req === 1'b1 && m_addr === addr), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, at, n0, idx;
        logic [31:0] nxt;
        rst = 1'b1; c_req = 1'b0; c_addr = '0; c_w_rb = 1'b0; c_acc = 2'd2;
        c_wdata = 32'hDEAD_BEEF; fault_addr = 32'h1;
        repeat (3) @(posedge clk); #1;
        check("rst_c_resp", c_resp, 1'b0);
        check("rst_c_fault", c_fault, 1'b0);
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_m_req", m_req, 1'b0);
        check("rst_m_addr", m_addr, 32'h0);
        check("tie_m_w_rb", m_w_rb, 1'b0);
        check("tie_m_acc", m_acc, 2'd2);
        check("tie_m_wdata", m_wdata, 32'h0);
        rst = 1'b0;
        idle(2);

        // Sequential hits
        fetch(32'h100, 2'd2, 1'b0, "seq0", lat, at);
        check("seq0_cold_latency", at - resp_cyc[32'h100], 2);
        for (int i = 1; i < 4; i++) begin
            idle(10);
            fetch(32'h100 + 32'(4 * i), 2'd2, 1'b0, $sformatf("seq%0d", i), lat, at);
            check($sformatf("seq%0d_hit_latency", i), lat, 1);
        end

        // Branch while a prefetch is outstanding
        fetch(32'h100, 2'd2, 1'b0, "br_start", lat, at);
        wait_maddr(32'h108, "br_pf108");
        fetch(32'h200, 2'd2, 1'b0, "br_target", lat, at);
        idx = -1;
        foreach (issued[i]) if (issued[i] == 32'h108) idx = i;
        nxt = (idx >= 0 && idx + 1 < issued.size()) ? issued[idx + 1] : 32'hFFFF_FFFF;
        check("br_next_issue", nxt, 32'h200);

        // Faulting prefetch stops the stream
        fault_addr = 32'h404;
        fetch(32'h400, 2'd2, 1'b0, "flt0", lat, at);
        idle(12);
        n0 = issued.size();
        fetch(32'h404, 2'd2, 1'b0, "flt_hit", lat, at);
        check("flt_hit_latency", lat, 1);
        idle(10);
        check("flt_no_m_req", m_req, 1'b0);
        check("flt_no_issue", issued.size(), n0);
        fetch(32'h408, 2'd2, 1'b0, "flt_refetch", lat, at);
        nxt = (issued.size() > n0) ? issued[n0] : 32'hFFFF_FFFF;
        check("flt_refetch_issue", nxt, 32'h408);
        fault_addr = 32'h1;

        // Illegal requests leave the buffer alone
        idle(15);
        n0 = issued.size();
        check("ill_idle", m_req, 1'b0);
        fetch(32'h40C, 2'd1, 1'b0, "ill_acc", lat, at);
        check("ill_acc_latency", lat, 1);
        fetch(32'h40C, 2'd2, 1'b1, "ill_wrb", lat, at);
        check("ill_wrb_latency", lat, 1);
        fetch(32'h40E, 2'd2, 1'b0, "ill_align", lat, at);
        check("ill_align_latency", lat, 1);
        check("ill_no_issue", issued.size(), n0);
        check("ill_no_m_req", m_req, 1'b0);
        fetch(32'h40C, 2'd2, 1'b0, "ill_after", lat, at);
        check("ill_after_latency", lat, 1);

        // Address wrap stops prefetch
        fetch(32'hFFFF_FFF8, 2'd2, 1'b0, "wrap0", lat, at);
        idle(12);
        n0 = issued.size();
        fetch(32'hFFFF_FFFC, 2'd2, 1'b0, "wrap1", lat, at);
        check("wrap1_latency", lat, 1);
        idle(10);
        check("wrap_no_m_req", m_req, 1'b0);
        check("wrap_no_issue", issued.size(), n0);
        fetch(32'h0, 2'd2, 1'b0, "wrap_zero", lat, at);
        nxt = (issued.size() > n0) ? issued[n0] : 32'hFFFF_FFFF;
        check("wrap_zero_issue", nxt, 32'h0);

        // Asynchronous reset mid-transaction
        fetch(32'h500, 2'd2, 1'b0, "rst0", lat, at);
        wait_maddr(32'h508, "rst_pf508");
        #2 rst = 1'b1;
        #1;
        check("arst_m_req", m_req, 1'b0);
        check("arst_m_addr", m_addr, 32'h0);
        check("arst_c_resp", c_resp, 1'b0);
        check("arst_c_fault", c_fault, 1'b0);
        check("arst_c_rdata", c_rdata, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        fetch(32'h504, 2'd2, 1'b0, "rst_cold", lat, at);
        check("rst_cold_latency", at - resp_cyc[32'h504], 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
